// File: rtl/pellet_eater_if.sv
// pellet_eater_if: tile visit request handshake and map BRAM port bundle.
// Parameters mirror pellet_eater so both ends agree on the widths.
//   tile_valid / tile_ready : visit request handshake (accepted when both high)
//   tile_x / tile_y         : tile column / row of the request
//   bram_addr / bram_we / bram_din : map BRAM address, write enable, write data
//   bram_dout               : map BRAM registered read data (one-cycle latency)
// modport slave  : the pellet_eater side
// modport master : the requester plus the BRAM side
interface pellet_eater_if #(
   parameter int DATA_WIDTH = 4,
   parameter int DATA_DEPTH = 1023,
   parameter int MAP_COLS   = 32
);
   logic                          tile_valid;
   logic                          tile_ready;
   logic [$clog2(MAP_COLS)-1:0]   tile_x;
   logic [4:0]                    tile_y;
   logic [$clog2(DATA_DEPTH)-1:0] bram_addr;
   logic                          bram_we;
   logic [DATA_WIDTH-1:0]         bram_din;
   logic [DATA_WIDTH-1:0]         bram_dout;
   modport slave (
      input  tile_valid, tile_x, tile_y, bram_dout,
      output tile_ready, bram_addr, bram_we, bram_din
   );
   modport master (
      output tile_valid, tile_x, tile_y, bram_dout,
      input  tile_ready, bram_addr, bram_we, bram_din
   );
endinterface

// File: rtl/pellet_eater.sv
// pellet_eater: visits map tiles, eats pellets from the map BRAM and keeps score.
// Ports:
//   clk, rst_n    : single clock, asynchronous active-low reset
//   bus (slave)   : tile request handshake plus map BRAM port
//   new_level     : level reload request pulse
//   map_reload    : one-cycle pulse to the map BRAM soft reset
//   score         : saturating score
//   pellets_left  : pellets remaining, floors at 0
//   power_pulse   : high during the EVAL cycle that eats a POWER tile
//   level_clear   : high while pellets_left is 0
// Build option: define PELLET_EATER_POWER_EN to make POWER tiles worth 50 and
// raise power_pulse; otherwise they score 10 like a pellet.
module pellet_eater #(
   parameter int DATA_WIDTH   = 4,
   parameter int DATA_DEPTH   = 1023,
   parameter int MAP_COLS     = 32,
   parameter int PELLET_TOTAL = 244
) (
   input  logic          clk,
   input  logic          rst_n,
   pellet_eater_if.slave bus,
   input  logic          new_level,
   output logic          map_reload,
   output logic [15:0]   score,
   output logic [8:0]    pellets_left,
   output logic          power_pulse,
   output logic          level_clear
);
   localparam int AW = $clog2(DATA_DEPTH);
   localparam int CW = $clog2(DATA_DEPTH + 2);
   typedef enum logic [1:0] {IDLE, READ, EVAL, RELOAD} state_t;
   state_t        state;
   logic          in_rng;
   logic          pend;
   logic [CW-1:0] cnt;
   logic [31:0]   full_addr;
   logic          is_pel;
   logic          is_pow;
   logic          eat;
   logic          go_rl;
   logic [16:0]   sum;
   assign full_addr = 32'(bus.tile_y) * 32'(MAP_COLS) + 32'(bus.tile_x);
   assign is_pel = bus.bram_dout == DATA_WIDTH'(2);
   assign is_pow = bus.bram_dout == DATA_WIDTH'(3);
   // bram_dout is only valid in EVAL, so the write is decided combinationally
   // there; out-of-range requests never write.
   assign eat = state == EVAL && in_rng && (is_pel || is_pow);
`ifdef PELLET_EATER_POWER_EN
   assign power_pulse = eat && is_pow;
   assign sum = {1'b0, score} + (is_pow ? 17'd50 : 17'd10);
`else
   assign power_pulse = 1'b0;
   assign sum = {1'b0, score} + 17'd10;
`endif
   assign bus.tile_ready = state == IDLE;
   assign bus.bram_we = eat;
   assign bus.bram_din = '0;
   assign level_clear = pellets_left == 9'd0;
   // A reload seen in IDLE beats a request; one seen mid-request waits until
   // EVAL finishes and then goes straight to RELOAD.
   assign go_rl = (state == IDLE && new_level) || (state == EVAL && (pend || new_level));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state         <= IDLE;
         score         <= '0;
         pellets_left  <= 9'(PELLET_TOTAL);
         bus.bram_addr <= '0;
         map_reload    <= 1'b0;
         pend          <= 1'b0;
         in_rng        <= 1'b0;
         cnt           <= '0;
      end else begin
         map_reload <= 1'b0;
         case (state)
            IDLE:
               if (bus.tile_valid && !new_level) begin
                  bus.bram_addr <= full_addr[AW-1:0];
                  in_rng        <= full_addr < 32'(DATA_DEPTH);
                  state         <= READ;
               end
            READ: begin
               pend  <= pend | new_level;
               state <= EVAL;
            end
            EVAL: begin
               if (eat) begin
                  score        <= sum[16] ? 16'hFFFF : sum[15:0];
                  pellets_left <= level_clear ? 9'd0 : pellets_left - 9'd1;
               end
               state <= IDLE;
            end
            RELOAD: begin
               cnt <= cnt + 1'b1;
               if (cnt == CW'(DATA_DEPTH)) state <= IDLE;
            end
         endcase
         if (go_rl) begin
            state        <= RELOAD;
            map_reload   <= 1'b1;
            pellets_left <= 9'(PELLET_TOTAL);
            cnt          <= '0;
            pend         <= 1'b0;
         end
      end
endmodule

// File: tb/tb_pellet_eater.sv
// tb_pellet_eater: directed self-checking bench for pellet_eater.
module tb_pellet_eater;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        new_level = 1'b0;
   logic        map_reload, power_pulse, level_clear;
   logic        map_reload2, power_pulse2, level_clear2;
   logic [15:0] score, score2;
   logic [8:0]  pellets_left, pellets_left2;
   logic [3:0]  mem [0:1023];
   logic        ld_en = 1'b0;
   logic [9:0]  ld_a = '0;
   logic [3:0]  ld_v = '0;
   int          n_chk = 0;
   int          n_fail = 0;
`ifdef PELLET_EATER_POWER_EN
   localparam int   PW = 50;
   localparam logic PP = 1'b1;
`else
   localparam int   PW = 10;
   localparam logic PP = 1'b0;
`endif

   always #5 clk = ~clk;

   pellet_eater_if #(.DATA_WIDTH(4), .DATA_DEPTH(1023), .MAP_COLS(32)) bus ();
   pellet_eater_if #(.DATA_WIDTH(4), .DATA_DEPTH(1023), .MAP_COLS(32)) bus2 ();

   pellet_eater #(.DATA_WIDTH(4), .DATA_DEPTH(1023), .MAP_COLS(32), .PELLET_TOTAL(244)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave), .new_level(new_level),
      .map_reload(map_reload), .score(score), .pellets_left(pellets_left),
      .power_pulse(power_pulse), .level_clear(level_clear));

   pellet_eater #(.DATA_WIDTH(4), .DATA_DEPTH(1023), .MAP_COLS(32), .PELLET_TOTAL(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .bus(bus2.slave), .new_level(1'b0),
      .map_reload(map_reload2), .score(score2), .pellets_left(pellets_left2),
      .power_pulse(power_pulse2), .level_clear(level_clear2));

   // map BRAM: registered read, write port, plus a bench preload port
   always @(posedge clk) begin
      if (ld_en) mem[ld_a] <= ld_v;
      else if (bus.bram_we) mem[bus.bram_addr] <= bus.bram_din;
      bus.bram_dout <= mem[bus.bram_addr];
   end

   // second instance sees a pellet on every read
   always @(posedge clk) bus2.bram_dout <= 4'd2;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic req(input int x, input int y);
      bus.tile_x = 5'(x);
      bus.tile_y = 5'(y);
      bus.tile_valid = 1'b1;
      @(posedge clk);
      #1 bus.tile_valid = 1'b0;
   endtask

   task automatic req2();
      bus2.tile_valid = 1'b1;
      @(posedge clk);
      #1 bus2.tile_valid = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic poke(input int a, input int v);
      ld_a = 10'(a);
      ld_v = 4'(v);
      ld_en = 1'b1;
      @(posedge clk);
      #1 ld_en = 1'b0;
   endtask

   initial begin
      int n;
      int xs [3] = '{1, 2, 4};
      int ys [3] = '{1, 0, 3};
      bus.tile_valid = 1'b0;
      bus.tile_x = '0;
      bus.tile_y = '0;
      bus2.tile_valid = 1'b0;
      bus2.tile_x = '0;
      bus2.tile_y = '0;
      poke(67, 2); poke(164, 3); poke(33, 1); poke(2, 0); poke(100, 7);
      poke(1023, 2); poke(68, 2); poke(69, 2); poke(70, 2);
      @(negedge clk);
      chk("rst_ready", bus.tile_ready, 1);
      chk("rst_score", score, 0);
      chk("rst_left", pellets_left, 244);
      chk("rst_we", bus.bram_we, 0);
      chk("rst_addr", bus.bram_addr, 0);
      chk("rst_din", bus.bram_din, 0);
      chk("rst_reload", map_reload, 0);
      chk("rst_power", power_pulse, 0);
      chk("rst_clear", level_clear, 0);
      rst_n = 1'b1;
      // pellet at (3,2) -> address 67
      req(3, 2);
      @(negedge clk);
      chk("rd_ready", bus.tile_ready, 0);
      chk("rd_addr", bus.bram_addr, 67);
      chk("rd_we", bus.bram_we, 0);
      @(negedge clk);
      chk("ev_we", bus.bram_we, 1);
      chk("ev_addr", bus.bram_addr, 67);
      chk("ev_din", bus.bram_din, 0);
      chk("ev_ready", bus.tile_ready, 0);
      @(negedge clk);
      chk("pel_ready", bus.tile_ready, 1);
      chk("pel_score", score, 10);
      chk("pel_left", pellets_left, 243);
      chk("pel_mem", mem[67], 0);
      // power tile at (4,5) -> address 164
      req(4, 5);
      @(negedge clk);
      chk("pw_pre", power_pulse, 0);
      @(negedge clk);
      chk("pw_pulse", power_pulse, PP);
      chk("pw_we", bus.bram_we, 1);
      @(negedge clk);
      chk("pw_off", power_pulse, 0);
      chk("pw_score", score, 10 + PW);
      chk("pw_left", pellets_left, 242);
      // wall, empty and an unknown code never eat
      for (int i = 0; i < 3; i++) begin
         req(xs[i], ys[i]);
         @(negedge clk);
         @(negedge clk);
         chk("ne_we", bus.bram_we, 0);
         @(negedge clk);
         chk("ne_ready", bus.tile_ready, 1);
         chk("ne_score", score, 10 + PW);
         chk("ne_left", pellets_left, 242);
      end
      // out-of-range address 1023 holds a pellet code but must not be eaten
      req(31, 31);
      @(negedge clk);
      chk("oob_addr", bus.bram_addr, 1023);
      @(negedge clk);
      chk("oob_we", bus.bram_we, 0);
      @(negedge clk);
      chk("oob_ready", bus.tile_ready, 1);
      chk("oob_score", score, 10 + PW);
      chk("oob_left", pellets_left, 242);
      chk("oob_mem", mem[1023], 2);
      // reload arriving mid-request: request finishes, then RELOAD
      req(4, 2);
      @(negedge clk);
      new_level = 1'b1;
      @(posedge clk);
      #1 new_level = 1'b0;
      @(negedge clk);
      chk("pd_we", bus.bram_we, 1);
      @(negedge clk);
      chk("pd_reload", map_reload, 1);
      chk("pd_ready", bus.tile_ready, 0);
      chk("pd_left", pellets_left, 244);
      chk("pd_score", score, 20 + PW);
      n = 0;
      while (bus.tile_ready !== 1'b1 && n < 1100) begin
         n++;
         @(negedge clk);
         if (n == 1) chk("pd_reload_1cyc", map_reload, 0);
      end
      chk("pd_len", n, 1024);
      // reload together with a request in IDLE: reload wins, request dropped
      new_level = 1'b1;
      req(5, 2);
      new_level = 1'b0;
      @(negedge clk);
      chk("rl_reload", map_reload, 1);
      chk("rl_ready", bus.tile_ready, 0);
      chk("rl_addr", bus.bram_addr, 68);
      chk("rl_left", pellets_left, 244);
      n = 0;
      while (bus.tile_ready !== 1'b1 && n < 1100) begin
         n++;
         @(negedge clk);
         if (n == 1) chk("rl_reload_1cyc", map_reload, 0);
         chk("rl_we", bus.bram_we, 0);
      end
      chk("rl_len", n, 1024);
      chk("rl_score", score, 20 + PW);
      chk("rl_mem", mem[69], 2);
      // reset during EVAL aborts the write
      req(6, 2);
      @(negedge clk);
      @(negedge clk);
      chk("rs_we", bus.bram_we, 1);
      rst_n = 1'b0;
      #1;
      chk("rs_we_drop", bus.bram_we, 0);
      chk("rs_score", score, 0);
      chk("rs_ready", bus.tile_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      chk("rs_mem", mem[70], 2);
      req(6, 2);
      @(negedge clk);
      chk("rs_first_acc", bus.tile_ready, 0);
      @(negedge clk);
      @(negedge clk);
      chk("rs_score2", score, 10);
      chk("rs_left2", pellets_left, 243);
      chk("rs_mem2", mem[70], 0);
      // PELLET_TOTAL = 2: clear, floor at 0, then score saturation
      chk("c0_left", pellets_left2, 2);
      req2();
      chk("c1_left", pellets_left2, 1);
      chk("c1_clear", level_clear2, 0);
      req2();
      chk("c2_left", pellets_left2, 0);
      chk("c2_clear", level_clear2, 1);
      chk("c2_score", score2, 20);
      req2();
      chk("c3_left", pellets_left2, 0);
      chk("c3_clear", level_clear2, 1);
      chk("c3_score", score2, 30);
      chk("c3_ready", bus2.tile_ready, 1);
      repeat (6550) req2();
      chk("sat_pre", score2, 65530);
      req2();
      chk("sat_hit", score2, 16'hFFFF);
      req2();
      chk("sat_hold", score2, 16'hFFFF);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/pellet_eater.md
PELLET_EATER -- requirements
Module: pellet_eater

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4: map tile code width; matches map BRAM word.
REQ-002 SHALL have parameter DATA_DEPTH, default 1023: map BRAM depth; address width is $clog2(DATA_DEPTH).
REQ-003 SHALL have parameter MAP_COLS, default 32: tiles per row, power of two; address = tile_y*MAP_COLS + tile_x.
REQ-004 SHALL have parameter PELLET_TOTAL, default 244: pellet count loaded at reset and on level reload.
REQ-005 SHALL have ports: clk in 1, single clock; rst_n in 1, asynchronous active-low reset.
REQ-006 SHALL have ports: tile_valid in 1, visit request; tile_ready out 1, request accepted when both high.
REQ-007 SHALL have ports: tile_x in $clog2(MAP_COLS), column; tile_y in 5, row.
REQ-008 SHALL have ports: bram_addr out $clog2(DATA_DEPTH); bram_we out 1; bram_din out DATA_WIDTH; bram_dout in DATA_WIDTH, registered read data, one-cycle latency.
REQ-009 SHALL have ports: new_level in 1, reload pulse; map_reload out 1, one-cycle pulse to the BRAM soft_rst.
REQ-010 SHALL have ports: score out 16; pellets_left out 9; power_pulse out 1; level_clear out 1.

Function
REQ-011 SHALL use tile codes 0 EMPTY, 1 WALL, 2 PELLET, 3 POWER; all other codes are treated as WALL.
REQ-012 SHALL implement FSM states IDLE, READ, EVAL, RELOAD.
REQ-013 IDLE: tile_ready=1; on tile_valid, latch the address and go to READ; tile_ready=0 in every other state.
REQ-014 READ: drive bram_addr with the latched address, bram_we=0; go to EVAL next cycle.
REQ-015 EVAL: sample bram_dout. For PELLET or POWER, drive bram_we=1 and bram_din=0 at the same address, decrement pellets_left, and add 10 (PELLET) or 50 (POWER) to score. Return to IDLE.
REQ-016 Request latency SHALL be exactly 3 cycles from acceptance until tile_ready is high again.
REQ-017 An address >= DATA_DEPTH SHALL be accepted, then complete in 3 cycles with bram_we=0 and no score or count change.
REQ-018 score SHALL saturate at 16'hFFFF.
REQ-019 pellets_left SHALL not decrement below 0.
REQ-020 level_clear SHALL be high while pellets_left==0; requests are still served.
REQ-021 power_pulse SHALL be high for exactly the one EVAL cycle that consumes a POWER tile.
REQ-022 new_level sampled in IDLE SHALL take priority over a simultaneous tile_valid; that request is not accepted.
REQ-023 new_level in READ or EVAL SHALL be held pending; that request completes first.
REQ-024 Entering RELOAD SHALL pulse map_reload for 1 cycle and reload pellets_left to PELLET_TOTAL; score is kept.
REQ-025 RELOAD SHALL last DATA_DEPTH+1 cycles with bram_we=0, then return to IDLE.
REQ-026 bram_addr SHALL hold its last value in IDLE and RELOAD; bram_we is 0 outside EVAL.

Reset
REQ-027 rst_n low SHALL asynchronously force: state IDLE, score 0, pellets_left PELLET_TOTAL, bram_we 0, bram_addr 0, bram_din 0, map_reload 0, power_pulse 0, pending reload cleared.
REQ-028 Reset asserted mid-request SHALL abort the request with no BRAM write.
REQ-029 Deassertion SHALL be synchronised by the integrator; first accept is possible on the first clk edge after release.

Configuration
REQ-030 Macro PELLET_EATER_POWER_EN defined: POWER tiles score 50 and raise power_pulse.
REQ-031 Macro PELLET_EATER_POWER_EN undefined: code 3 scores 10 like PELLET and is cleared; power_pulse is tied to 0.

Verification
REQ-032 Pellet: tile (3,2)=2 at addr 67, valid 1 cycle -> bram_we=1 and addr=67/din=0 on cycle 3; score 10; pellets_left 243; ready high again after 3 cycles.
REQ-033 Power, with macro defined: tile code 3 -> score +50, power_pulse high exactly 1 cycle. Without macro: score +10, power_pulse stays 0.
REQ-034 Wall or empty: tile code 1 or 0 -> no bram_we; score and pellets_left unchanged.
REQ-035 Clear: PELLET_TOTAL=2, eat two pellets -> level_clear=1; third pellet read -> score +10, pellets_left stays 0.
REQ-036 Reload: new_level together with tile_valid in IDLE -> map_reload 1 cycle, ready=0 for 1024 cycles, pellets_left=PELLET_TOTAL, score retained.
REQ-037 Reset: rst_n low during EVAL -> bram_we drops immediately; score 0 and state IDLE after release.
